// File: rtl/packet_rx.sv
// packet_rx: RMII Ethernet frame receiver with a fixed-length payload.
// Finds the preamble/SFD, filters on destination MAC (station or broadcast),
// strips the 14-byte header and streams the payload out as AXI-Stream words
// through a small FIFO. The final payload word is held back until the FCS has
// been checked, so tuser on the tlast beat carries the frame verdict.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   crs_dv, rxd         RMII receive (rxd LSB-first within each byte)
//   m_axis_*            payload stream; tuser on the tlast beat = frame error
//   rx_good/bad/drop    one-cycle status pulses, never more than one at a time
module packet_rx #(
  parameter logic [47:0] LOCAL_MAC            = 48'h00_18_3e_04_b3_f2,
  parameter int          MII_WIDTH            = 2,
  parameter int          PACKET_PAYLOAD_WORDS = 128,
  parameter int          WORD_BYTES           = 1,
  parameter int          FIFO_DEPTH           = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    crs_dv,
  input  logic [MII_WIDTH-1:0]    rxd,
  output logic [WORD_BYTES*8-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  input  logic                    m_axis_tready,
  output logic                    rx_good,
  output logic                    rx_bad,
  output logic                    rx_drop
);

  localparam int W       = WORD_BYTES * 8;
  localparam int BCYC    = 8 / MII_WIDTH;
  localparam int WCYC    = W / MII_WIDTH;
  localparam int FCYC    = 32 / MII_WIDTH;
  localparam int PH_MAX  = (WCYC > FCYC) ? WCYC : FCYC;
  localparam int PH_W    = $clog2(PH_MAX + 1);
  localparam int IDX_MAX = (PACKET_PAYLOAD_WORDS > 14) ? PACKET_PAYLOAD_WORDS : 14;
  localparam int IDX_W   = $clog2(IDX_MAX + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [PH_W-1:0]  B_LAST   = PH_W'(BCYC - 1);
  localparam logic [PH_W-1:0]  W_LAST   = PH_W'(WCYC - 1);
  localparam logic [PH_W-1:0]  F_LAST   = PH_W'(FCYC - 1);
  localparam logic [IDX_W-1:0] H_LAST   = IDX_W'(13);
  localparam logic [IDX_W-1:0] DST_LAST = IDX_W'(5);
  localparam logic [IDX_W-1:0] P_LAST   = IDX_W'(PACKET_PAYLOAD_WORDS - 1);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, DATA, FCS, DISCARD} state_t;

  // Reflected Ethernet CRC-32, rxd[0] is the earlier bit on the wire.
  function automatic logic [31:0] crc_step(input logic [31:0] c,
                                           input logic [MII_WIDTH-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < MII_WIDTH; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  state_t               state_q, state_d;
  logic [MII_WIDTH-1:0] rxd_q, rxd_d;
  logic                 crs_q, crs_d, crs_prev_q, crs_prev_d;
  logic [7:0]           sr_q, sr_d;
  logic [W-1:0]         wsr_q, wsr_d, wsr_sh;
  logic [47:0]          dst_q, dst_d;
  logic [31:0]          crc_q, crc_d;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 mism_q, mism_d, ovf_q, ovf_d;
  logic                 good_q, good_d, bad_q, bad_d, drop_q, drop_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          fcnt_q, fcnt_d;

  logic                 push, push_last, push_user;
  logic [W-1:0]         push_data;
  logic                 pop, full, room, fcs_bad;
  logic                 mem_we;
  logic [AW-1:0]        mem_wa;
  logic [W+1:0]         mem_wd, head;
  logic [W+1:0]         mem_q [FIFO_DEPTH];

  always_comb begin
    rxd_d      = rxd;
    crs_d      = crs_dv;
    crs_prev_d = crs_q;
    state_d    = state_q;
    // The SFD hunter shifts every cycle; it is only looked at in PREAMBLE.
    sr_d       = {rxd_q, sr_q[7:MII_WIDTH]};
    wsr_sh     = {rxd_q, wsr_q[W-1:MII_WIDTH]};
    wsr_d      = wsr_q;
    dst_d      = dst_q;
    crc_d      = crc_q;
    ph_d       = ph_q;
    idx_d      = idx_q;
    mism_d     = mism_q;
    ovf_d      = ovf_q;
    good_d     = 1'b0;
    bad_d      = 1'b0;
    drop_d     = 1'b0;
    push       = 1'b0;
    push_last  = 1'b0;
    push_user  = 1'b0;
    push_data  = '0;
    // The FCS is sent as ~crc, LSB first; crc_q is shifted down during FCS.
    fcs_bad    = (rxd_q != ~crc_q[MII_WIDTH-1:0]);
    pop        = m_axis_tvalid && m_axis_tready;
    full       = (fcnt_q == FULL_CNT);
    room       = !full || pop;

    case (state_q)
      IDLE: begin
        crc_d = '1;
        ph_d  = '0;
        idx_d = '0;
        if (crs_q && !crs_prev_q) state_d = PREAMBLE;
      end
      PREAMBLE: begin
        if (!crs_q) state_d = IDLE;
        else if (sr_d == 8'hD5) begin
          state_d = HEADER;
          ovf_d   = 1'b0;
          mism_d  = 1'b0;
        end
      end
      HEADER: begin
        if (!crs_q) begin
          drop_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wsr_d = wsr_sh;
          crc_d = crc_step(crc_q, rxd_q);
          if (ph_q == B_LAST) begin
            ph_d  = '0;
            idx_d = idx_q + 1'b1;
            if (idx_q <= DST_LAST) dst_d = {dst_q[39:0], wsr_sh[W-1 -: 8]};
            if (idx_q == H_LAST) begin
              idx_d = '0;
              if (dst_q == LOCAL_MAC || dst_q == '1) state_d = DATA;
              else begin
                state_d = DISCARD;
                drop_d  = 1'b1;
              end
            end
          end else ph_d = ph_q + 1'b1;
        end
      end
      DATA: begin
        if (!crs_q) begin
          push = 1'b1; push_last = 1'b1; push_user = 1'b1;
          bad_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wsr_d = wsr_sh;
          crc_d = crc_step(crc_q, rxd_q);
          if (ph_q == W_LAST) begin
            ph_d = '0;
            // Last word stays in wsr_q until the FCS verdict is known.
            if (idx_q == P_LAST) state_d = FCS;
            else begin
              push      = 1'b1;
              push_data = wsr_sh;
              idx_d     = idx_q + 1'b1;
            end
          end else ph_d = ph_q + 1'b1;
        end
      end
      FCS: begin
        if (!crs_q) begin
          push = 1'b1; push_last = 1'b1; push_user = 1'b1;
          bad_d   = 1'b1;
          state_d = IDLE;
        end else begin
          crc_d  = crc_q >> MII_WIDTH;
          mism_d = mism_q | fcs_bad;
          if (ph_q == F_LAST) begin
            push      = 1'b1;
            push_last = 1'b1;
            push_data = wsr_q;
            // !room: the tlast beat overwrites a word, so the frame is damaged.
            push_user = mism_q | fcs_bad | ovf_q | !room;
            good_d    = !push_user;
            bad_d     = push_user;
            state_d   = DISCARD;
          end else ph_d = ph_q + 1'b1;
        end
      end
      DISCARD: if (!crs_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // FIFO: data words drop when full; the tlast beat always lands.
    mem_we   = 1'b0;
    mem_wa   = wr_ptr_q;
    mem_wd   = {push_user, push_last, push_data};
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    if (push) begin
      if (room) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else if (push_last) begin
        mem_we = 1'b1;
        mem_wa = wr_ptr_q - 1'b1;
      end else ovf_d = 1'b1;
    end
    fcnt_d = fcnt_q + (AW + 1)'(push && room) - (AW + 1)'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rxd_q      <= '0;
      // Seeded high so a carrier already present at release is not an edge.
      crs_q      <= 1'b1;
      crs_prev_q <= 1'b1;
      sr_q       <= '0;
      wsr_q      <= '0;
      dst_q      <= '0;
      crc_q      <= '1;
      ph_q       <= '0;
      idx_q      <= '0;
      mism_q     <= 1'b0;
      ovf_q      <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      drop_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      rxd_q      <= rxd_d;
      crs_q      <= crs_d;
      crs_prev_q <= crs_prev_d;
      sr_q       <= sr_d;
      wsr_q      <= wsr_d;
      dst_q      <= dst_d;
      crc_q      <= crc_d;
      ph_q       <= ph_d;
      idx_q      <= idx_d;
      mism_q     <= mism_d;
      ovf_q      <= ovf_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  // Storage is not reset; gate the head so outputs read 0 when empty.
  assign head          = mem_q[rd_ptr_q];
  assign m_axis_tvalid = (fcnt_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[W-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & head[W];
  assign m_axis_tuser  = m_axis_tvalid & head[W+1];
  assign rx_good       = good_q;
  assign rx_bad        = bad_q;
  assign rx_drop       = drop_q;

endmodule
